// File: rtl/output_psum_accumulator.sv
// Read-modify-write psum accumulator in front of the output SRAM (read-and-clear on port 1, write-back on port 2).
// Optional macro ACCUM_SAT_EN: saturating lane adds instead of modulo-2^LANE_W wrap.

module psum_lane #(
    parameter int LANE_W = 16
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] sum
);
`ifdef ACCUM_SAT_EN
    logic [LANE_W:0] full;
    assign full = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    // Sign-extension bit disagreeing with the MSB means the signed add overflowed.
    always_comb begin
        sum = full[LANE_W-1:0];
        if (full[LANE_W] != full[LANE_W-1])
            sum = full[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    end
`else
    assign sum = a + b;
`endif
endmodule

module output_psum_accumulator #(
    parameter int LANES  = 32,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psum_valid_in,
    output logic                      psum_ready_out,
    input  logic [ADDR_W-1:0]         psum_addr_in,
    input  logic [LANES*LANE_W-1:0]   psum_data_in,
    input  logic                      psum_first_in,
    output logic                      mem_rd_valid_out,
    output logic [ADDR_W-1:0]         mem_rd_addr_out,
    output logic [LANES*LANE_W-1:0]   mem_rd_data_out,
    input  logic [LANES*LANE_W-1:0]   mem_rd_data_in,
    output logic                      mem_wr_valid_out,
    output logic [ADDR_W-1:0]         mem_wr_addr_out,
    output logic [LANES*LANE_W-1:0]   mem_wr_data_out,
    output logic                      busy_out,
    output logic [15:0]               wb_count_out
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [ADDR_W-1:0]                 addr;
        logic [LANES-1:0][LANE_W-1:0]      psum;
        logic [LANES-1:0][LANE_W-1:0]      stored;
    } s1_t;

    typedef struct packed {
        logic [ADDR_W-1:0]                 addr;
        logic [LANES-1:0][LANE_W-1:0]      sum;
    } s2_t;

    logic [STAGES:1]              vld_pipe;
    s1_t                          s1;
    s2_t                          s2;
    logic [LANES-1:0][LANE_W-1:0] sum_s1;
    logic [15:0]                  wb_count;
    logic                         hazard;
    logic                         xfer;

    // Any in-flight word to the same address would make the read stale or collide with its clear.
    assign hazard = psum_valid_in &&
                    ((vld_pipe[1] && s1.addr == psum_addr_in) ||
                     (vld_pipe[2] && s2.addr == psum_addr_in));
    assign psum_ready_out = !rst && !hazard;
    assign xfer           = psum_valid_in && psum_ready_out;

    assign mem_rd_valid_out = xfer && !psum_first_in;
    assign mem_rd_addr_out  = mem_rd_valid_out ? psum_addr_in : '0;
    assign mem_rd_data_out  = '0;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            psum_lane #(.LANE_W(LANE_W)) u_lane (
                .a   (s1.psum[i]),
                .b   (s1.stored[i]),
                .sum (sum_s1[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            wb_count <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
            if (vld_pipe[STAGES])
                wb_count <= wb_count + 16'd1;
        end
    end

    // First pass zeroes the stored operand so the write-back simply overwrites.
    always_ff @(posedge clk) begin
        if (xfer) begin
            s1.addr   <= psum_addr_in;
            s1.psum   <= psum_data_in;
            s1.stored <= psum_first_in ? '0 : mem_rd_data_in;
        end
        if (vld_pipe[1]) begin
            s2.addr <= s1.addr;
            s2.sum  <= sum_s1;
        end
    end

    assign mem_wr_valid_out = vld_pipe[STAGES] && !rst;
    assign mem_wr_addr_out  = mem_wr_valid_out ? s2.addr : '0;
    assign mem_wr_data_out  = mem_wr_valid_out ? s2.sum  : '0;
    assign busy_out         = (|vld_pipe) && !rst;
    assign wb_count_out     = wb_count;
endmodule

// File: tb/tb_output_psum_accumulator.sv
// Directed bench for output_psum_accumulator with a behavioural read-and-clear output memory.
module tb_output_psum_accumulator;
    logic         clk = 1'b0;
    logic         rst;
    logic         psum_valid_in, psum_first_in, psum_ready_out;
    logic [7:0]   psum_addr_in;
    logic [511:0] psum_data_in;
    logic         mem_rd_valid_out, mem_wr_valid_out, busy_out;
    logic [7:0]   mem_rd_addr_out, mem_wr_addr_out;
    logic [511:0] mem_rd_data_out, mem_rd_data_in, mem_wr_data_out;
    logic [15:0]  wb_count_out;
    logic [511:0] mem [0:255];
    logic [511:0] exp_pos, exp_neg;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    output_psum_accumulator dut (
        .clk              (clk),
        .rst              (rst),
        .psum_valid_in    (psum_valid_in),
        .psum_ready_out   (psum_ready_out),
        .psum_addr_in     (psum_addr_in),
        .psum_data_in     (psum_data_in),
        .psum_first_in    (psum_first_in),
        .mem_rd_valid_out (mem_rd_valid_out),
        .mem_rd_addr_out  (mem_rd_addr_out),
        .mem_rd_data_out  (mem_rd_data_out),
        .mem_rd_data_in   (mem_rd_data_in),
        .mem_wr_valid_out (mem_wr_valid_out),
        .mem_wr_addr_out  (mem_wr_addr_out),
        .mem_wr_data_out  (mem_wr_data_out),
        .busy_out         (busy_out),
        .wb_count_out     (wb_count_out)
    );

    // Output SRAM: port-1 read returns data in the same cycle and stores its (zero) write data.
    assign mem_rd_data_in = mem[mem_rd_addr_out];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (mem_rd_valid_out) mem[mem_rd_addr_out] <= mem_rd_data_out;
            if (mem_wr_valid_out) mem[mem_wr_addr_out] <= mem_wr_data_out;
        end
    end

    function automatic logic [511:0] lanes(input logic [15:0] v);
        return {32{v}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [7:0] a, input logic [511:0] d);
        psum_valid_in = v;
        psum_first_in = f;
        psum_addr_in  = a;
        psum_data_in  = d;
    endtask

    initial begin
`ifdef ACCUM_SAT_EN
        exp_pos = lanes(16'h7fff);
        exp_neg = lanes(16'h8000);
`else
        exp_pos = lanes(16'h8000);
        exp_neg = lanes(16'h7fff);
`endif
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, '0);
        nxt(); nxt();
        chk("rst_ready", psum_ready_out, 0);
        chk("rst_rd_valid", mem_rd_valid_out, 0);
        chk("rst_wr_valid", mem_wr_valid_out, 0);
        chk("rst_wr_data", mem_wr_data_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_wb_count", wb_count_out, 0);
        rst = 1'b0; #1;
        chk("idle_ready", psum_ready_out, 1);
        chk("idle_busy", busy_out, 0);

        // first pass: overwrite addr 5 with 3
        nxt(); drive(1'b1, 1'b1, 8'd5, lanes(16'd3)); #1;
        chk("first_ready", psum_ready_out, 1);
        chk("first_no_read", mem_rd_valid_out, 0);
        nxt(); drive(1'b0, 1'b0, 8'd0, '0); #1;
        chk("first_busy_s1", busy_out, 1);
        chk("first_no_wr_t1", mem_wr_valid_out, 0);
        nxt(); #1;
        chk("first_wr_valid", mem_wr_valid_out, 1);
        chk("first_wr_addr", mem_wr_addr_out, 8'd5);
        chk("first_wr_data", mem_wr_data_out, lanes(16'd3));
        nxt(); #1;
        chk("first_wb_count", wb_count_out, 16'd1);
        chk("first_idle_busy", busy_out, 0);
        chk("first_idle_wr_addr", mem_wr_addr_out, 0);

        // accumulate 4 onto stored 3
        drive(1'b1, 1'b0, 8'd5, lanes(16'd4)); #1;
        chk("acc_rd_valid", mem_rd_valid_out, 1);
        chk("acc_rd_addr", mem_rd_addr_out, 8'd5);
        chk("acc_rd_data_zero", mem_rd_data_out, 0);
        nxt(); drive(1'b0, 1'b0, 8'd0, '0);
        nxt(); #1;
        chk("acc_wr_addr", mem_wr_addr_out, 8'd5);
        chk("acc_wr_data", mem_wr_data_out, lanes(16'd7));
        nxt(); #1;
        chk("acc_wb_count", wb_count_out, 16'd2);

        // repeated address 9: one accept every 3 cycles
        drive(1'b1, 1'b0, 8'd9, lanes(16'd1)); #1;
        chk("rep_t0_ready", psum_ready_out, 1);
        nxt(); #1;
        chk("rep_t1_ready", psum_ready_out, 0);
        chk("rep_t1_no_read", mem_rd_valid_out, 0);
        nxt(); #1;
        chk("rep_t2_ready", psum_ready_out, 0);
        chk("rep_t2_wr_addr", mem_wr_addr_out, 8'd9);
        chk("rep_t2_wr_data", mem_wr_data_out, lanes(16'd1));
        nxt(); #1;
        chk("rep_t3_ready", psum_ready_out, 1);
        nxt(); #1;
        chk("rep_t4_ready", psum_ready_out, 0);
        nxt(); #1;
        chk("rep_t5_ready", psum_ready_out, 0);
        chk("rep_t5_wr_data", mem_wr_data_out, lanes(16'd2));
        nxt(); #1;
        chk("rep_t6_ready", psum_ready_out, 1);
        nxt(); #1;
        chk("rep_t7_ready", psum_ready_out, 0);
        chk("rep_t7_no_wr", mem_wr_valid_out, 0);
        nxt(); drive(1'b0, 1'b0, 8'd0, '0); #1;
        chk("rep_t8_wr_addr", mem_wr_addr_out, 8'd9);
        chk("rep_t8_wr_data", mem_wr_data_out, lanes(16'd3));

        // alternating 1,2,1,2
        nxt(); drive(1'b1, 1'b0, 8'd1, lanes(16'd10)); #1;
        chk("alt_a_ready", psum_ready_out, 1);
        nxt(); drive(1'b1, 1'b0, 8'd2, lanes(16'd20)); #1;
        chk("alt_b_ready", psum_ready_out, 1);
        nxt(); drive(1'b1, 1'b0, 8'd1, lanes(16'd30)); #1;
        chk("alt_c_ready", psum_ready_out, 0);
        chk("alt_c_wr_data", mem_wr_data_out, lanes(16'd10));
        nxt(); #1;
        chk("alt_d_ready", psum_ready_out, 1);
        chk("alt_d_wr_addr", mem_wr_addr_out, 8'd2);
        chk("alt_d_wr_data", mem_wr_data_out, lanes(16'd20));
        nxt(); drive(1'b1, 1'b0, 8'd2, lanes(16'd40)); #1;
        chk("alt_e_ready", psum_ready_out, 1);
        nxt(); drive(1'b0, 1'b0, 8'd0, '0); #1;
        chk("alt_f_wr_addr", mem_wr_addr_out, 8'd1);
        chk("alt_f_wr_data", mem_wr_data_out, lanes(16'd40));
        nxt(); #1;
        chk("alt_g_wr_addr", mem_wr_addr_out, 8'd2);
        chk("alt_g_wr_data", mem_wr_data_out, lanes(16'd60));

        // overflow: 32767+1 at addr 3, -32768+(-1) at addr 4
        nxt(); drive(1'b1, 1'b1, 8'd3, lanes(16'h7fff));
        nxt(); drive(1'b1, 1'b1, 8'd4, lanes(16'h8000));
        nxt(); drive(1'b0, 1'b0, 8'd0, '0);
        nxt(); drive(1'b1, 1'b0, 8'd3, lanes(16'd1)); #1;
        chk("ovf_pos_ready", psum_ready_out, 1);
        nxt(); drive(1'b1, 1'b0, 8'd4, lanes(16'hffff)); #1;
        chk("ovf_neg_ready", psum_ready_out, 1);
        nxt(); drive(1'b0, 1'b0, 8'd0, '0); #1;
        chk("ovf_pos_addr", mem_wr_addr_out, 8'd3);
        chk("ovf_pos_data", mem_wr_data_out, exp_pos);
        nxt(); #1;
        chk("ovf_neg_addr", mem_wr_addr_out, 8'd4);
        chk("ovf_neg_data", mem_wr_data_out, exp_neg);

        // reset while S1 holds a word: write must be dropped
        nxt(); drive(1'b1, 1'b1, 8'd20, lanes(16'd5));
        nxt(); drive(1'b0, 1'b0, 8'd0, '0); rst = 1'b1; #1;
        chk("mid_rst_ready", psum_ready_out, 0);
        chk("mid_rst_wr_valid", mem_wr_valid_out, 0);
        nxt(); rst = 1'b0; #1;
        chk("post_rst_busy", busy_out, 0);
        chk("post_rst_wr_valid", mem_wr_valid_out, 0);
        chk("post_rst_ready", psum_ready_out, 1);
        nxt(); #1;
        chk("post_rst_dropped_wr", mem_wr_valid_out, 0);
        chk("post_rst_wb_count", wb_count_out, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
